// File: rtl/seq_mul_256.sv
// Constant-latency 256x256 unsigned shift-and-add multiplier producing a 512-bit product.
// Define SEQ_MUL_RADIX4_EN to retire two multiplier bits per RUN cycle (latency W/2 instead of W).
module seq_mul_256 #(
   parameter int W = 256
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] product,
   output logic           done,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(W) + 1;
`ifdef SEQ_MUL_RADIX4_EN
   localparam int STEPS = W / 2;
`else
   localparam int STEPS = W;
`endif
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   state_t         state;
   state_t         state_next;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] addend;
   logic           accept;
   logic           last_step;

   // A new operation can only be taken when no multiplication is in flight.
   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign last_step = (state == RUN) && (cnt == LAST_STEP);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: default assignment first keeps this combinational block from inferring a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    if (accept) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      done = (state == DONE);
      busy = (state == RUN);
   end

`ifdef SEQ_MUL_RADIX4_EN
   always_comb begin
      addend = '0;
      case (mplier[1:0])
         2'd1:    addend = mcand;
         2'd2:    addend = mcand << 1;
         2'd3:    addend = mcand + (mcand << 1);
         default: addend = '0;
      endcase
   end
`else
   always_comb begin
      addend = mplier[0] ? mcand : '0;
   end
`endif

   // Every RUN cycle does identical work regardless of operand values, so latency leaks nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (state == RUN) begin
         acc <= acc + addend;
         cnt <= cnt + CW'(1);
`ifdef SEQ_MUL_RADIX4_EN
         mcand  <= mcand << 2;
         mplier <= mplier >> 2;
`else
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
`endif
      end
   end

   assign product = acc;

endmodule

// File: tb/tb_seq_mul_256.sv
// Scoreboard bench for seq_mul_256: driver queues expected products, a monitor checks them on done.
// Follows SEQ_MUL_RADIX4_EN for the expected latency.
module tb_seq_mul_256;

   localparam int W = 256;
`ifdef SEQ_MUL_RADIX4_EN
   localparam int LAT = W / 2;
`else
   localparam int LAT = W;
`endif

   typedef struct {
      logic [2*W-1:0] prod;
      int             acc_cyc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [2*W-1:0] product;
   logic           done;
   logic           busy;

   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   exp_t           sb[$];
   logic           done_q = 1'b0;
   logic [2*W-1:0] held;

   logic [W-1:0]   q;
   logic [W-1:0]   ones;

   seq_mul_256 #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .done    (done),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare product and latency when done rises, and product stability while done holds.
   always @(negedge clk) begin
      if (done === 1'b1 && !done_q) begin
         if (sb.size() == 0) begin
            check("unexpected_done", {511'd0, done}, 512'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", product, e.prod);
            check("latency", 512'(cyc - e.acc_cyc), 512'(LAT));
            held = product;
         end
      end else if (done === 1'b1 && done_q) begin
         check("product_stable", product, held);
      end
      done_q <= (done === 1'b1);
   end

   // Drive an accepted start; operands are scrambled afterwards to prove they are not resampled.
   task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] exp);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      a = ia;
      b = ib;
      @(posedge clk);
      #1;
      e.prod = exp;
      e.acc_cyc = cyc;
      sb.push_back(e);
      check("busy_after_accept", {511'd0, busy}, 512'd1);
      check("done_low_after_accept", {511'd0, done}, 512'd0);
      @(negedge clk);
      start = 1'b0;
      a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4 * LAT; i++) begin
         @(posedge clk);
         if (sb.size() == 0) break;
      end
      check("completion_timeout", 512'(sb.size()), 512'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      q = (256'd1 << 255) - 256'd19;
      ones = '1;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_product", product, 512'd0);
      check("reset_done", {511'd0, done}, 512'd0);
      check("reset_busy", {511'd0, busy}, 512'd0);

      start_op(256'd1 << 255, 256'd2, 512'd1 << 256);
      wait_idle();

      start_op(ones, ones, {512{1'b1}} - (512'd1 << 257) + 512'd2);
      wait_idle();

      start_op(256'd0, q, 512'd0);
      wait_idle();

      start_op(q, q, (512'd1 << 510) - (512'd19 << 256) + 512'd361);
      wait_idle();

      // A start raised mid-run must be ignored: result stays 3*5 at the normal time.
      start_op(256'd3, 256'd5, 512'd15);
      repeat (99) @(negedge clk);
      start = 1'b1;
      a = 256'd7;
      b = 256'd7;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Back-to-back start from DONE.
      start_op(256'd7, 256'd7, 512'd49);
      wait_idle();

      // Reset in the middle of a run aborts it with nothing exposed.
      start_op(256'd12345, 256'd678, 512'd8369910);
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrun_reset_product", product, 512'd0);
      check("midrun_reset_done", {511'd0, done}, 512'd0);
      check("midrun_reset_busy", {511'd0, busy}, 512'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_reset_done", {511'd0, done}, 512'd0);

      start_op(256'hFFFF_FFFF, 256'h1_0000_0001, 512'hFFFF_FFFF_FFFF_FFFF);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
